// File: rtl/req_responder_pkg.sv
// Shared definitions for the request responder: default sizes and the
// service state encoding.
package req_responder_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 3;
  localparam int DEF_LAT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

endpackage

// File: rtl/req_responder_if.sv
// Request/acknowledge bus between a requester (master) and the responder
// (slave).
//
// Handshake: in single-shot mode (is_ss=1) every cycle with req=1 is one
// request on channel req_sel, and the responder answers each one with a
// single-cycle ack tagged by ack_sel. In level mode (is_ss=0) req is a level:
// the responder raises ack after its busy latency and keeps it high until it
// samples req low, then drops ack on the following cycle (four-phase).
interface req_responder_if
  import req_responder_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int LAT_W  = DEF_LAT_W
) ();
  localparam int SEL_W = $clog2(NUM_CH);

  logic              req;
  logic [SEL_W-1:0]  req_sel;
  logic              is_ss;
  logic [LAT_W-1:0]  latency;
  logic              ack;
  logic [SEL_W-1:0]  ack_sel;
  logic              busy;
  logic [NUM_CH-1:0] pending;
  logic              overflow;

  modport master (
    output req, req_sel, is_ss, latency,
    input  ack, ack_sel, busy, pending, overflow
  );

  modport slave (
    input  req, req_sel, is_ss, latency,
    output ack, ack_sel, busy, pending, overflow
  );
endinterface

// File: rtl/req_responder_rr_picker.sv
// Combinational round-robin picker: returns the first set bit of mask_i
// searching upward from last_i+1 with wrap-around.
module rr_picker
  import req_responder_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [SEL_W-1:0]  last_i,
  output logic              valid_o,
  output logic [SEL_W-1:0]  ch_o
);

  logic [SEL_W-1:0] idx;

  // Walk the channels after last_i in order; the first pending one wins.
  always_comb begin
    valid_o = 1'b0;
    ch_o    = '0;
    idx     = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = SEL_W'((int'(last_i) + k) % NUM_CH);
      if (!valid_o && mask_i[idx]) begin
        valid_o = 1'b1;
        ch_o    = idx;
      end
    end
  end

endmodule

// File: rtl/req_responder.sv
// Request responder: counts single-shot request pulses per channel, services
// them round-robin one at a time with a programmable busy latency, and also
// supports a four-phase level handshake.
module req_responder
  import req_responder_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int LAT_W  = DEF_LAT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  req_responder_if.slave     bus,
  output state_e             dbg_state_o
);

  localparam int              SEL_W   = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q [NUM_CH];
  logic [CNT_W-1:0]   cnt_d [NUM_CH];
  logic [SEL_W-1:0]   rr_last_q, rr_last_d;
  logic [LAT_W-1:0]   timer_q, timer_d;
  logic               mode_ss_q, mode_ss_d;
  logic               ack_q, ack_d;
  logic [SEL_W-1:0]   ack_sel_q, ack_sel_d;
  logic               ovf_q, ovf_d;

  logic [NUM_CH-1:0]  pend;
  logic               pick_valid;
  logic [SEL_W-1:0]   pick_ch;
  logic               grant_ss;

  // A channel is pending whenever its pulse counter is nonzero.
  always_comb begin
    pend = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pend[i] = (cnt_q[i] != '0);
    end
  end

  rr_picker #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_picker (
    .mask_i  (pend),
    .last_i  (rr_last_q),
    .valid_o (pick_valid),
    .ch_o    (pick_ch)
  );

  // Service FSM next state: grant in IDLE, count down latency, then ack.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    mode_ss_d = mode_ss_q;
    ack_sel_d = ack_sel_q;
    rr_last_d = rr_last_q;
    grant_ss  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.is_ss) begin
          if (pick_valid) begin
            grant_ss  = 1'b1;
            ack_sel_d = pick_ch;
            rr_last_d = pick_ch;
            timer_d   = bus.latency;
            mode_ss_d = 1'b1;
            state_d   = ST_BUSY;
          end
        end else if (bus.req) begin
          ack_sel_d = bus.req_sel;
          timer_d   = bus.latency;
          mode_ss_d = 1'b0;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (timer_q != '0) begin
          timer_d = timer_q - LAT_ONE;
        end else begin
          state_d = mode_ss_q ? ST_ACK : ST_HOLD;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      ST_HOLD: begin
        if (!bus.req) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // ack is registered so it lines up exactly with ACK/HOLD occupancy.
    ack_d = (state_d == ST_ACK) || (state_d == ST_HOLD);
  end

  // Pending counters: decrement on grant, then add the incoming pulse; the
  // saturation test uses the net value so a same-cycle grant makes room.
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (grant_ss && (pick_ch == SEL_W'(i))) begin
        cnt_d[i] = cnt_d[i] - CNT_ONE;
      end
      if (bus.is_ss && bus.req && (bus.req_sel == SEL_W'(i))) begin
        if (cnt_d[i] == CNT_MAX) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d[i] = cnt_d[i] + CNT_ONE;
        end
      end
    end
  end

  // State and output registers; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      mode_ss_q <= 1'b0;
      ack_q     <= 1'b0;
      ack_sel_q <= '0;
      ovf_q     <= 1'b0;
      rr_last_q <= SEL_W'(NUM_CH - 1);
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      mode_ss_q <= mode_ss_d;
      ack_q     <= ack_d;
      ack_sel_q <= ack_sel_d;
      ovf_q     <= ovf_d;
      rr_last_q <= rr_last_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.ack      = ack_q;
  assign bus.ack_sel  = ack_sel_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.pending  = pend;
  assign bus.overflow = ovf_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_req_responder.sv
// Testbench for req_responder: directed scenarios plus random traffic, all
// cycles checked against a schedule-based reference model.
module tb_req_responder;
  import req_responder_pkg::*;

  localparam int NUM_CH  = 4;
  localparam int CNT_MAX = 7;
  localparam int W       = 11;

  logic   clk;
  logic   rst_n;
  state_e dbg_state;

  req_responder_if bus_if ();

  req_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: counts per channel, round-robin pointer, and the
  // current service described by its grant-derived ack cycle.
  int m_cnt[NUM_CH];
  int m_rr;
  bit m_active;
  bit m_ss;
  int m_ch;
  int m_ack_start;
  bit m_ovf;
  int m_c = 0;

  int ack_cnt[NUM_CH];
  int ack_order[$];
  int ack_cyc[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, m_c);
    end
  endtask

  function automatic int order_at(input int k);
    return (k < ack_order.size()) ? ack_order[k] : -1;
  endfunction

  function automatic int cyc_at(input int k);
    return (k < ack_cyc.size()) ? ack_cyc[k] : -1000;
  endfunction

  // Advance the model across one rising edge with this cycle's inputs and
  // queue the outputs expected in the following cycle.
  task automatic model_edge(input logic r, input logic [1:0] s, input logic ss,
                            input logic [3:0] l, input logic rst);
    int g;
    logic [1:0] st;
    logic [3:0] pm;
    logic [W-1:0] e;
    if (rst) begin
      m_active = 1'b0;
      m_ss     = 1'b0;
      m_ch     = 0;
      m_ovf    = 1'b0;
      m_rr     = NUM_CH - 1;
      for (int k = 0; k < NUM_CH; k++) m_cnt[k] = 0;
    end else begin
      g = -1;
      if (m_active) begin
        // ss service ends after its single ack cycle; level ends when req drops during ack
        if (m_ss) begin
          if (m_c == m_ack_start) m_active = 1'b0;
        end else if (m_c >= m_ack_start && !r) begin
          m_active = 1'b0;
        end
      end else if (ss) begin
        for (int k = 1; k <= NUM_CH; k++) begin
          if (g < 0 && m_cnt[(m_rr + k) % NUM_CH] > 0) g = (m_rr + k) % NUM_CH;
        end
        if (g >= 0) begin
          m_cnt[g]--;
          m_rr        = g;
          m_active    = 1'b1;
          m_ss        = 1'b1;
          m_ch        = g;
          m_ack_start = m_c + 2 + int'(l);
        end
      end else if (r) begin
        m_active    = 1'b1;
        m_ss        = 1'b0;
        m_ch        = int'(s);
        m_ack_start = m_c + 2 + int'(l);
      end
      if (ss && r) begin
        if (m_cnt[s] == CNT_MAX) m_ovf = 1'b1;
        else m_cnt[s]++;
      end
    end
    m_c++;
    for (int k = 0; k < NUM_CH; k++) pm[k] = (m_cnt[k] != 0);
    if (!m_active) st = 2'd0;
    else if (m_c < m_ack_start) st = 2'd1;
    else st = m_ss ? 2'd2 : 2'd3;
    e = {st, m_ovf, pm, m_active, 2'(m_ch), (m_active && m_c >= m_ack_start)};
    exp_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic r, input logic [1:0] s, input logic ss,
                       input logic [3:0] l, input logic rst);
    logic [W-1:0] e;
    rst_n          = !rst;
    bus_if.req     = r;
    bus_if.req_sel = s;
    bus_if.is_ss   = ss;
    bus_if.latency = l;
    model_edge(r, s, ss, l, rst);
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check_eq("ack",      32'(bus_if.ack),       32'(e[0]));
    check_eq("ack_sel",  32'(bus_if.ack_sel),   32'(e[2:1]));
    check_eq("busy",     32'(bus_if.busy),      32'(e[3]));
    check_eq("pending",  32'(bus_if.pending),   32'(e[7:4]));
    check_eq("overflow", 32'(bus_if.overflow),  32'(e[8]));
    check_eq("state",    32'(dbg_state),        32'(e[10:9]));
    if (bus_if.ack === 1'b1 && !$isunknown(bus_if.ack_sel)) begin
      ack_cnt[bus_if.ack_sel]++;
      ack_order.push_back(int'(bus_if.ack_sel));
      ack_cyc.push_back(m_c);
    end
  endtask

  task automatic do_reset(input int n);
    repeat (n) cycle(1'b0, 2'd0, 1'b1, 4'd0, 1'b1);
  endtask

  task automatic idle(input int n, input logic ss, input logic [3:0] l);
    repeat (n) cycle(1'b0, 2'd0, ss, l, 1'b0);
  endtask

  task automatic clear_stats();
    for (int k = 0; k < NUM_CH; k++) ack_cnt[k] = 0;
    ack_order.delete();
    ack_cyc.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic       ss;
    logic       r;
    logic [1:0] s;
    logic [3:0] l;
    logic       rst;
    rst_n          = 1'b0;
    bus_if.req     = 1'b0;
    bus_if.req_sel = '0;
    bus_if.is_ss   = 1'b1;
    bus_if.latency = '0;
    @(negedge clk);

    // Single pulse, zero latency
    do_reset(2);
    clear_stats();
    cycle(1'b1, 2'd2, 1'b1, 4'd0, 1'b0);
    idle(6, 1'b1, 4'd0);
    check_eq("t1_acks_ch2", 32'(ack_cnt[2]), 32'd1);
    check_eq("t1_acks_total", 32'(ack_order.size()), 32'd1);
    check_eq("t1_ack_cycle", 32'(cyc_at(0)), 32'(m_c - 6 + 2));

    // Round-robin order: ch3 primes the pointer, then ch1, ch0, ch3 queue up
    do_reset(1);
    clear_stats();
    cycle(1'b1, 2'd3, 1'b1, 4'd3, 1'b0);
    cycle(1'b1, 2'd1, 1'b1, 4'd3, 1'b0);
    cycle(1'b1, 2'd0, 1'b1, 4'd3, 1'b0);
    cycle(1'b1, 2'd3, 1'b1, 4'd3, 1'b0);
    idle(30, 1'b1, 4'd3);
    check_eq("t2_n_acks", 32'(ack_order.size()), 32'd4);
    check_eq("t2_order0", 32'(order_at(0)), 32'd3);
    check_eq("t2_order1", 32'(order_at(1)), 32'd0);
    check_eq("t2_order2", 32'(order_at(2)), 32'd1);
    check_eq("t2_order3", 32'(order_at(3)), 32'd3);
    check_eq("t2_spacing", 32'(cyc_at(2) - cyc_at(1)), 32'd6);

    // Saturation of channel 0 while a long service is in flight
    do_reset(1);
    clear_stats();
    cycle(1'b1, 2'd0, 1'b1, 4'd15, 1'b0);
    cycle(1'b0, 2'd0, 1'b1, 4'd15, 1'b0);
    repeat (9) cycle(1'b1, 2'd0, 1'b1, 4'd15, 1'b0);
    check_eq("t3_ovf_set", 32'(bus_if.overflow), 32'd1);
    idle(150, 1'b1, 4'd15);
    check_eq("t3_acks_ch0", 32'(ack_cnt[0]), 32'd8);
    check_eq("t3_ovf_sticky", 32'(bus_if.overflow), 32'd1);

    // Pulse coinciding with the grant that empties the counter
    do_reset(1);
    clear_stats();
    cycle(1'b1, 2'd1, 1'b1, 4'd1, 1'b0);
    cycle(1'b1, 2'd1, 1'b1, 4'd1, 1'b0);
    idle(14, 1'b1, 4'd1);
    check_eq("t4_acks_ch1", 32'(ack_cnt[1]), 32'd2);

    // Level handshake with req_sel wandering during the service
    do_reset(1);
    clear_stats();
    cycle(1'b1, 2'd3, 1'b0, 4'd2, 1'b0);
    for (int k = 1; k < 10; k++) cycle(1'b1, 2'($urandom_range(0, 3)), 1'b0, 4'd2, 1'b0);
    cycle(1'b0, 2'($urandom_range(0, 3)), 1'b0, 4'd2, 1'b0);
    idle(4, 1'b0, 4'd2);
    check_eq("t5_ack_cycles", 32'(ack_cnt[3]), 32'd7);
    check_eq("t5_ack_total", 32'(ack_order.size()), 32'd7);

    // Reset in the middle of a service
    do_reset(1);
    clear_stats();
    cycle(1'b1, 2'd2, 1'b1, 4'd10, 1'b0);
    idle(4, 1'b1, 4'd10);
    cycle(1'b0, 2'd0, 1'b1, 4'd10, 1'b1);
    idle(20, 1'b1, 4'd10);
    check_eq("t6_no_ack", 32'(ack_order.size()), 32'd0);

    // Random traffic
    do_reset(1);
    ss = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 49) == 0) ss = ~ss;
      r   = ($urandom_range(0, 2) == 0);
      s   = 2'($urandom_range(0, 3));
      l   = 4'($urandom_range(0, 5));
      rst = ($urandom_range(0, 299) == 0);
      cycle(r, s, ss, l, rst);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/req_responder.md
Name: req_responder

Overview:
- Responder end of the request interface driven by req_singleshot. Accepts requests tagged with a 2-bit channel select and services them one at a time with a programmable busy latency.
- Returns an acknowledge tagged with the serviced channel.
- Single-shot mode: request pulses are counted per channel and arbitrated round-robin.
- Level mode: four-phase req/ack handshake.

Parameters:
- NUM_CH, 4, number of request channels (req_sel width = log2(NUM_CH) = 2)
- CNT_W, 3, per-channel pending counter width (max 7 outstanding pulses per channel)
- LAT_W, 4, width of latency input

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- req  input  1  request: pulse (single-shot mode) or level (level mode)
- req_sel  input  2  channel tag qualifying req
- is_ss  input  1  1 = single-shot mode, 0 = level mode
- latency  input  LAT_W  extra busy cycles per service; sampled at grant
- ack  output  1  acknowledge; one-cycle pulse (ss) or held (level)
- ack_sel  output  2  channel being serviced/acknowledged
- busy  output  1  high when state != IDLE
- pending  output  NUM_CH  bit i = pending counter i nonzero
- overflow  output  1  sticky: a pulse was lost to a saturated counter

Behaviour:
Reset:
- rst_n=0 at a rising clk edge forces: state IDLE, all counters 0, ack 0, ack_sel 0, overflow 0, timer 0, rr_last = NUM_CH-1 (channel 0 has first priority).
- Reset mid-service drops the transaction; no ack is issued.

States: IDLE, BUSY, ACK, HOLD.
- Mode is sampled only in IDLE. An is_ss change mid-transaction takes effect at the next IDLE.

Counting (active when is_ss=1, in any state):
- req=1 → cnt[req_sel] += 1 at the edge.
- At max (2^CNT_W-1) the counter holds and overflow is set.
- overflow clears only on reset.
- Level mode never increments counters. Held counts are serviced after returning to ss mode.

IDLE, ss mode:
- If any cnt nonzero, pick the first nonzero channel searching from rr_last+1 with wrap.
- At the edge: decrement that counter, ack_sel <= ch, rr_last <= ch, timer <= latency, → BUSY.
- Simultaneous increment and decrement on the same channel nets zero; saturation is checked on the net result.

IDLE, level mode:
- If req=1: ack_sel <= req_sel, timer <= latency, → BUSY.

BUSY:
- timer != 0: decrement.
- timer == 0: → ACK (ss) or HOLD (level).
- Occupancy is latency+1 cycles.

ACK:
- ack=1 for exactly one cycle, then → IDLE.
- No back-to-back grant: IDLE always lasts at least one cycle.

HOLD:
- ack=1 while req=1.
- When req samples 0: → IDLE and ack=0 in the next cycle.
- req_sel changes during BUSY/HOLD are ignored.

Timing:
- ss: req pulse in cycle 0 → counter 1 in cycle 1 → BUSY from cycle 2 → ack in cycle 3+latency.
- level: req rises in cycle 0 → BUSY cycle 1 → ack rises in cycle 2+latency.

Outputs:
- All outputs are registered except busy and pending, which decode registered state only.
- ack_sel holds its last value in IDLE.

Decomposition:
- Shared package/header: state encodings (IDLE=0, BUSY=1, ACK=2, HOLD=3), NUM_CH, CNT_W and LAT_W defaults.
- One sub-module, rr_picker: combinational. Inputs are the pending mask and rr_last; outputs are a grant-valid flag and the 2-bit channel. It is reusable by other arbiters in the design.

Test Plan:
1. Reset then ss mode, latency=0, single req pulse on ch2 at cycle 0 → ack=1, ack_sel=2 in cycle 3 only; busy high in cycles 2-3; pending[2] high in cycle 1 only.
2. ss mode, latency=3, pulses on ch1, ch0, ch3 in consecutive cycles → acks in order ch0, ch1, ch3 (rr from rr_last=3); each ack one cycle; grants 6 cycles apart.
3. ss mode, 9 pulses on ch0 while BUSY with latency=15 → cnt[0] saturates at 7, overflow=1 and stays 1; exactly 7 subsequent acks on ch0 plus the in-flight one.
4. Pulse on ch1 in the same cycle its counter (=1) is decremented by a grant → counter stays 1, a second ch1 service follows.
5. Level mode, latency=2, req held high with req_sel=3 → ack rises in cycle 4 and stays high; drop req in cycle 10 → ack low in cycle 11, busy low in cycle 11.
6. rst_n=0 during BUSY → next cycle: state IDLE, ack 0, pending 0, overflow 0; no ack emitted afterwards.
